// File: rtl/f_round_back_pkg.sv
// Shared FP back-end definitions: rounding-mode codes, IEEE constants, flag indices, stage records.
// No logic of its own; latency and backpressure are defined by the modules that import it.
// Stage records are sized for the IEEE double format.
package f_round_back_pkg;

    localparam int EXP_W  = 11;
    localparam int FRAC_W = 52;
    localparam int LF_W   = 2*FRAC_W + 4;
    localparam int XE_W   = EXP_W + 2;

    typedef enum logic [1:0] {
        RM_RN = 2'd0,
        RM_RZ = 2'd1,
        RM_RP = 2'd2,
        RM_RM = 2'd3
    } rmode_e;

    localparam logic [63:0]     DEFAULT_DNAN = 64'h7FF7FFFFFFFFFFFF;
    localparam logic [XE_W-1:0] EXP_BIAS     = 13'd1023;
    localparam logic [XE_W:0]   EXP_MAX      = 14'd2047;

    localparam int FLAG_V = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_O = 2;
    localparam int FLAG_U = 1;
    localparam int FLAG_I = 0;

    typedef struct packed {
        logic             sign;
        logic [XE_W-1:0]  exp;
        logic [LF_W-1:0]  mag;
        logic [6:0]       lz;
        logic             zero;
        logic             invalid;
        rmode_e           rm;
    } s1_t;

    typedef struct packed {
        logic              sign;
        logic [XE_W-1:0]   exp;
        logic [FRAC_W-1:0] mant;
        logic              guard;
        logic              sticky;
        logic              zero;
        logic              invalid;
        logic              ftz;
        rmode_e            rm;
    } s2_t;

    function automatic logic round_inc(rmode_e rm, logic sign, logic lsb, logic guard, logic sticky);
        case (rm)
            RM_RN:   return guard & (sticky | lsb);
            RM_RP:   return !sign & (guard | sticky);
            RM_RM:   return sign & (guard | sticky);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/f_round_back_lzc108.sv
// Leading-zero counter over the 108-bit long fraction; returns 108 for an all-zero input.
// Latency: combinational.
// Backpressure: none, pure function of its input.
module f_lzc108 (
    input  logic [107:0] din,
    output logic [6:0]   lz
);

    always_comb begin
        lz = 7'd108;
        for (int i = 0; i < 108; i++) begin
            if (din[i]) lz = 7'(107 - i);
        end
    end

endmodule

// File: rtl/f_round_back.sv
// FP back end: normalise, round and pack a double from exponent + 108-bit signed fraction (FLUSH_DENORM_EN: flush subnormals to zero).
// Latency: 3 cycles, 1 op/cycle.
// Backpressure: a_wait freezes every stage and the outputs; flush clears all valids and wins over a_wait.
module f_round_back
    import f_round_back_pkg::*;
#(
    parameter int info_width = 1,
    parameter int exp_width  = 11,
    parameter int frac_width = 52
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      a_wait,
    input  logic                      flush,
    output logic                      busy,
    input  logic                      in_sign,
    input  logic [exp_width+1:0]      in_exp,
    input  logic [2*frac_width+3:0]   in_frac,
    input  logic                      in_invalid,
    input  logic [1:0]                rmode,
    input  logic [info_width-1:0]     info_in,
    output logic [63:0]               result,
    output logic [4:0]                flags,
    output logic [info_width-1:0]     info_out
);

    s1_t                   s1_n, s1_q;
    s2_t                   s2_n, s2_q;
    logic [info_width-1:0] s1_info, s2_info;
    logic [LF_W-1:0]       mag_c;
    logic [6:0]            lz_c;

    // S1: magnitude and leading-one detect
    assign mag_c = in_frac[LF_W-1] ? (~in_frac + 108'd1) : in_frac;

    f_lzc108 u_lzc (
        .din (mag_c),
        .lz  (lz_c)
    );

    always_comb begin
        s1_n         = '0;
        s1_n.sign    = in_sign ^ in_frac[LF_W-1];
        s1_n.exp     = in_exp;
        s1_n.mag     = mag_c;
        s1_n.lz      = lz_c;
        s1_n.zero    = (mag_c == '0);
        s1_n.invalid = in_invalid;
        s1_n.rm      = rmode_e'(rmode);
    end

    // S2: leading one is taken to bit 107 (two above the architectural bit 105),
    // so mantissa/guard/sticky sit two bits higher than the nominal 104:53/52/51:0.
    logic [LF_W-1:0]       norm;
    logic signed [XE_W:0]  e14;
    logic                  den;
    logic [2*LF_W-1:0]     wide;

    assign norm = s1_q.mag << s1_q.lz;
    assign e14  = $signed({s1_q.exp[XE_W-1], s1_q.exp}) + 14'sd2 - $signed({7'd0, s1_q.lz});
    assign den  = (e14 <= 14'sd0);

`ifdef FLUSH_DENORM_EN
    assign wide = {norm, {LF_W{1'b0}}};
`else
    logic signed [XE_W:0] sh_raw;
    logic [7:0]           sh;

    always_comb begin
        sh_raw = 14'sd1 - e14;
        sh     = 8'd0;
        if (den) sh = (sh_raw > 14'sd108) ? 8'd108 : sh_raw[7:0];
    end

    assign wide = {norm, {LF_W{1'b0}}} >> sh;
`endif

    always_comb begin
        s2_n         = '0;
        s2_n.sign    = s1_q.sign;
        s2_n.exp     = den ? '0 : e14[XE_W-1:0];
        s2_n.mant    = wide[214:163];
        s2_n.guard   = wide[162];
        s2_n.sticky  = |wide[161:0];
        s2_n.zero    = s1_q.zero;
        s2_n.invalid = s1_q.invalid;
`ifdef FLUSH_DENORM_EN
        s2_n.ftz     = den;
`else
        s2_n.ftz     = 1'b0;
`endif
        s2_n.rm      = s1_q.rm;
    end

    // S3: round and pack
    logic              inc;
    logic [FRAC_W:0]   sum;
    logic [XE_W:0]     e_r;
    logic              inexact;
    logic [63:0]       res_c;
    logic [4:0]        flg_c;

    always_comb begin
        inc     = round_inc(s2_q.rm, s2_q.sign, s2_q.mant[0], s2_q.guard, s2_q.sticky);
        sum     = {1'b0, s2_q.mant} + {{FRAC_W{1'b0}}, inc};
        e_r     = {1'b0, s2_q.exp} + {{XE_W{1'b0}}, sum[FRAC_W]};
        inexact = s2_q.guard | s2_q.sticky;
        res_c   = {s2_q.sign, e_r[EXP_W-1:0], sum[FRAC_W-1:0]};
        flg_c   = '0;
        flg_c[FLAG_I] = inexact;
        flg_c[FLAG_U] = inexact & (e_r == '0);

        if (s2_q.invalid) begin
            res_c         = DEFAULT_DNAN;
            flg_c         = '0;
            flg_c[FLAG_V] = 1'b1;
        end else if (s2_q.zero) begin
            res_c = {s2_q.sign, 63'd0};
            flg_c = '0;
        end else if (s2_q.ftz) begin
            res_c         = {s2_q.sign, 63'd0};
            flg_c         = '0;
            flg_c[FLAG_U] = 1'b1;
            flg_c[FLAG_I] = 1'b1;
        end else if (e_r >= EXP_MAX) begin
            flg_c         = '0;
            flg_c[FLAG_O] = 1'b1;
            flg_c[FLAG_I] = 1'b1;
            case (s2_q.rm)
                RM_RN:   res_c = {s2_q.sign, 11'h7FF, 52'd0};
                RM_RZ:   res_c = {s2_q.sign, 63'h7FEFFFFFFFFFFFFF};
                RM_RP:   res_c = s2_q.sign ? {1'b1, 63'h7FEFFFFFFFFFFFFF} : {1'b0, 11'h7FF, 52'd0};
                default: res_c = s2_q.sign ? {1'b1, 11'h7FF, 52'd0} : {1'b0, 63'h7FEFFFFFFFFFFFFF};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            s1_info  <= '0;
            s2_info  <= '0;
            result   <= '0;
            flags    <= '0;
            info_out <= '0;
        end else begin
            if (!a_wait) begin
                s1_q     <= s1_n;
                s1_info  <= info_in;
                s2_q     <= s2_n;
                s2_info  <= s1_info;
                info_out <= s2_info;
                if (s2_info[0]) begin
                    result <= res_c;
                    flags  <= flg_c;
                end
            end
            if (flush) begin
                s1_info[0]  <= 1'b0;
                s2_info[0]  <= 1'b0;
                info_out[0] <= 1'b0;
            end
        end
    end

    assign busy = s1_info[0] | s2_info[0] | info_out[0] | a_wait;

endmodule

// File: tb/tb_f_round_back.sv
// Directed bench for f_round_back: hand-computed vectors for rounding, overflow, subnormal, NaN and stall/flush protocol.
module tb_f_round_back;
    import f_round_back_pkg::*;

    logic          clk = 1'b0;
    logic          reset, a_wait, flush, busy;
    logic          in_sign, in_invalid;
    logic [12:0]   in_exp;
    logic [107:0]  in_frac;
    logic [1:0]    rmode;
    logic [0:0]    info_in, info_out;
    logic [63:0]   result;
    logic [4:0]    flags;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    f_round_back dut (
        .clk        (clk),
        .reset      (reset),
        .a_wait     (a_wait),
        .flush      (flush),
        .busy       (busy),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_frac    (in_frac),
        .in_invalid (in_invalid),
        .rmode      (rmode),
        .info_in    (info_in),
        .result     (result),
        .flags      (flags),
        .info_out   (info_out)
    );

    function automatic logic [107:0] b108(int b);
        logic [107:0] one;
        one = 108'd1;
        return one << b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic sgn, input logic [12:0] ex, input logic [107:0] fr,
                           input logic [1:0] rm, input logic inv);
        in_sign    = sgn;
        in_exp     = ex;
        in_frac    = fr;
        rmode      = rm;
        in_invalid = inv;
        info_in    = 1'b1;
        step();
        info_in    = 1'b0;
        in_invalid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [12:0] ex, input logic [107:0] fr,
                          input logic [1:0] rm, input logic inv, input logic [63:0] exp_res, input logic [4:0] exp_flg);
        present(sgn, ex, fr, rm, inv);
        step();
        step();
        chk({tag, ".vld"}, 64'(info_out[0]), 64'd1);
        chk({tag, ".res"}, result, exp_res);
        chk({tag, ".flg"}, 64'(flags), 64'(exp_flg));
        step();
        chk({tag, ".pulse"}, 64'(info_out[0]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         seen;
        logic [63:0]  held;

        reset = 1'b1; a_wait = 1'b0; flush = 1'b0;
        in_sign = 1'b0; in_exp = '0; in_frac = '0; in_invalid = 1'b0; rmode = RM_RN; info_in = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        chk("rst.result", result, 64'd0);
        chk("rst.flags", 64'(flags), 64'd0);
        chk("rst.info", 64'(info_out), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);

        run_op("one",      1'b0, EXP_BIAS, b108(105), RM_RN, 1'b0, 64'h3FF0000000000000, 5'b00000);
        run_op("tie_even", 1'b0, EXP_BIAS, b108(105) | b108(52), RM_RN, 1'b0, 64'h3FF0000000000000, 5'b00001);
        run_op("tie_up",   1'b0, EXP_BIAS, b108(105) | b108(53) | b108(52), RM_RN, 1'b0, 64'h3FF0000000000002, 5'b00001);
        run_op("two",      1'b0, EXP_BIAS, b108(106), RM_RN, 1'b0, 64'h4000000000000000, 5'b00000);
        run_op("neg_frac", 1'b0, EXP_BIAS, 108'd0 - b108(105), RM_RN, 1'b0, 64'hBFF0000000000000, 5'b00000);
        run_op("ovf_rn",   1'b0, 13'd2047, b108(105), RM_RN, 1'b0, 64'h7FF0000000000000, 5'b00101);
        run_op("ovf_rz",   1'b0, 13'd2047, b108(105), RM_RZ, 1'b0, 64'h7FEFFFFFFFFFFFFF, 5'b00101);
        run_op("ovf_rp_n", 1'b1, 13'd2047, b108(105), RM_RP, 1'b0, 64'hFFEFFFFFFFFFFFFF, 5'b00101);
        run_op("rp_up",    1'b0, EXP_BIAS, b108(105) | b108(0), RM_RP, 1'b0, 64'h3FF0000000000001, 5'b00001);
        run_op("zero_neg", 1'b1, EXP_BIAS, 108'd0, RM_RN, 1'b0, 64'h8000000000000000, 5'b00000);
`ifdef FLUSH_DENORM_EN
        run_op("subnorm",  1'b0, 13'd0, b108(105), RM_RN, 1'b0, 64'h0000000000000000, 5'b00011);
`else
        run_op("subnorm",  1'b0, 13'd0, b108(105), RM_RN, 1'b0, 64'h0008000000000000, 5'b00000);
`endif
        run_op("invalid",  1'b0, EXP_BIAS, b108(105), RM_RN, 1'b1, 64'h7FF7FFFFFFFFFFFF, 5'b10000);

        // op at t, flush at t+1: must never emerge
        present(1'b0, EXP_BIAS, b108(105), RM_RN, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush.busy", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (4) begin
            seen |= info_out[0];
            step();
        end
        chk("flush.nopulse", 64'(seen), 64'd0);

        // op at t, a_wait over t+1..t+2: result at t+5 and held through a later stall
        present(1'b0, EXP_BIAS, b108(106), RM_RN, 1'b0);
        a_wait = 1'b1;
        step();
        chk("stall.busy", 64'(busy), 64'd1);
        step();
        a_wait = 1'b0;
        step();
        chk("stall.early", 64'(info_out[0]), 64'd0);
        step();
        chk("stall.vld", 64'(info_out[0]), 64'd1);
        chk("stall.res", result, 64'h4000000000000000);
        held = result;
        a_wait = 1'b1;
        step();
        step();
        chk("stall.hold_vld", 64'(info_out[0]), 64'd1);
        chk("stall.hold_res", result, held);
        a_wait = 1'b0;
        step();
        chk("stall.release", 64'(info_out[0]), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
